// File: rtl/inst_issue_ctrl.sv
// Issue controller between fetch and execute: latches one fetched word, drives the decoder,
// classifies op-groups and issues to one unit. Optional perf counters: ISSUE_PERF_CNT_EN.
module inst_issue_ctrl #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [XLEN-1:0]  if_instr,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_ready,
    output logic [XLEN-1:0]  dec_instruction_code,
    output logic             dec_en,
    input  logic [31:0]      dec_invalid,
    input  logic [18:0]      dec_alu_op,
    input  logic [8:0]       dec_jmp_op,
    input  logic [8:0]       dec_mem_op,
    input  logic [5:0]       dec_csr_op,
    input  logic [0:0]       dec_cust_op,
    input  logic [7:0]       dec_mechie_op,
    output logic             iss_valid,
    output logic [2:0]       iss_unit,
    output logic [XLEN-1:0]  iss_instr,
    output logic [XLEN-1:0]  iss_pc,
    input  logic [5:0]       unit_ready,
    input  logic             unit_done,
    input  logic             flush,
    output logic             trap_valid,
    output logic             trap_cause,
    output logic [XLEN-1:0]  trap_pc,
    input  logic             trap_ack,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        ISSUE,
        WAIT_SER,
        TRAP
    } state_t;

    localparam logic [2:0] U_ALU  = 3'd0;
    localparam logic [2:0] U_JMP  = 3'd1;
    localparam logic [2:0] U_MEM  = 3'd2;
    localparam logic [2:0] U_CSR  = 3'd3;
    localparam logic [2:0] U_CUST = 3'd4;
    localparam logic [2:0] U_SYS  = 3'd5;

    state_t          state, state_nx;
    logic [XLEN-1:0] instr_q, pc_q;
    logic [2:0]      unit_q;
    logic            cause_q;

    logic [5:0] grp_hit;
    logic [2:0] hits;
    logic [2:0] hit_unit;
    logic       illegal, multi_hit;
    logic       accept, ready_sel, handshake, serialising;

    assign grp_hit = {|dec_mechie_op, |dec_cust_op, |dec_csr_op,
                      |dec_mem_op, |dec_jmp_op, |dec_alu_op};

    always_comb begin
        hits     = '0;
        hit_unit = U_ALU;
        for (int unsigned i = 0; i < 6; i++) begin
            hits = hits + {2'b00, grp_hit[i]};
            if (grp_hit[i]) hit_unit = 3'(i);
        end
    end

    assign illegal   = (dec_invalid != '0) || (hits == 3'd0);
    assign multi_hit = (hits > 3'd1);

    assign if_ready    = (state == IDLE) && !flush && !rst;
    assign accept      = if_valid && if_ready;
    assign ready_sel   = (unit_q <= U_SYS) ? unit_ready[unit_q] : 1'b0;
    assign handshake   = (state == ISSUE) && ready_sel;
    assign serialising = (unit_q == U_JMP) || (unit_q == U_CSR) || (unit_q == U_SYS);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (accept) state_nx = DECODE;
            DECODE: begin
                if (flush)                       state_nx = IDLE;
                else if (illegal || multi_hit)   state_nx = TRAP;
                else                             state_nx = ISSUE;
            end
            // A handshake wins over flush: the unit already owns the instruction,
            // but flush still suppresses the serialising wait.
            ISSUE: begin
                if (handshake)   state_nx = (serialising && !flush) ? WAIT_SER : IDLE;
                else if (flush)  state_nx = IDLE;
            end
            WAIT_SER: if (flush || unit_done) state_nx = IDLE;
            TRAP:     if (trap_ack) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            instr_q <= '0;
            pc_q    <= '0;
            unit_q  <= '0;
            cause_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                instr_q <= if_instr;
                pc_q    <= if_pc;
            end else if (flush && state != TRAP) begin
                instr_q <= '0;
                pc_q    <= '0;
            end
            if (state == DECODE && !flush) begin
                if (illegal || multi_hit) cause_q <= !illegal;
                else                      unit_q  <= hit_unit;
            end
        end
    end

    assign dec_instruction_code = instr_q;
    assign dec_en               = (state == DECODE);
    assign iss_valid            = (state == ISSUE);
    assign iss_unit             = unit_q;
    assign iss_instr            = instr_q;
    assign iss_pc               = pc_q;
    assign trap_valid           = (state == TRAP);
    assign trap_cause           = cause_q;
    assign trap_pc              = pc_q;

`ifdef ISSUE_PERF_CNT_EN
    logic [CNT_W-1:0] issue_cnt_q, stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (handshake)                      issue_cnt_q <= issue_cnt_q + 1'b1;
            if (state == ISSUE && !ready_sel)   stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign issue_cnt = issue_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign issue_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule
